// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM state and be-decode payload.
// Used by ahb_be_decode and ahb_ri5cy_master.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE     = 3'b000,
        HSIZE_HALFWORD = 3'b001,
        HSIZE_WORD     = 3'b010
    } hsize_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10
    } ahb_state_e;

    typedef struct packed {
        logic [2:0] hsize;
        logic [1:0] offset;
    } be_dec_t;

endpackage

// File: rtl/ahb_be_decode.sv
// Maps core byte enables onto AHB transfer size and byte offset.
module ahb_be_decode
    import ahb_pkg::*;
(
    input  logic [3:0] i_be,
    output be_dec_t    o_dec
);

    always_comb begin
        o_dec.hsize  = HSIZE_WORD;
        o_dec.offset = 2'b00;
        case (i_be)
            4'b0011: o_dec.hsize = HSIZE_HALFWORD;
            4'b1100: begin
                o_dec.hsize  = HSIZE_HALFWORD;
                o_dec.offset = 2'b10;
            end
            4'b0001: o_dec.hsize = HSIZE_BYTE;
            4'b0010: begin
                o_dec.hsize  = HSIZE_BYTE;
                o_dec.offset = 2'b01;
            end
            4'b0100: begin
                o_dec.hsize  = HSIZE_BYTE;
                o_dec.offset = 2'b10;
            end
            4'b1000: begin
                o_dec.hsize  = HSIZE_BYTE;
                o_dec.offset = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_ri5cy_master.sv
// AHB-Lite initiator for the RI5CY OBI-style port: combinational address phase,
// one outstanding data phase. Optional AHB_MASTER_RSP_REG_EN registers the response.
module ahb_ri5cy_master
    import ahb_pkg::*;
#(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [AHB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic [1:0]                htrans_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);

    ahb_state_e                r_state;
    ahb_state_e                w_state_nxt;
    logic                      r_valid;
    logic                      w_valid_nxt;
    logic [AHB_DATA_WIDTH-1:0] r_hwdata;
    be_dec_t                   w_dec;
    logic                      w_cancel;
    logic                      w_gnt;
    logic                      w_rvalid;
    logic                      w_err;
    logic                      w_unused_addr_lo;

    ahb_be_decode u_be_decode (
        .i_be  (be_i),
        .o_dec (w_dec)
    );

    // ERR1 blocks the address phase; reset blocks it so nothing is granted into a lost stage.
    assign w_cancel = rst || (r_state == ST_ERR1);
    assign w_gnt    = req_i && hready_i && !w_cancel;
    assign w_rvalid = r_valid && hready_i && !rst;
    assign w_err    = w_rvalid && hresp_i;

    // Low address bits are replaced by the be-derived byte offset.
    assign w_unused_addr_lo = ^addr_i[1:0];

    assign haddr_o     = {addr_i[AHB_ADDR_WIDTH-1:2], w_dec.offset};
    assign hwrite_o    = we_i;
    assign hsize_o     = w_dec.hsize;
    assign hburst_o    = HBURST_SINGLE;
    assign hprot_o     = HPROT_VAL;
    assign htrans_o    = (req_i && !w_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hmastlock_o = 1'b0;
    assign gnt_o       = w_gnt;
    assign hwdata_o    = r_hwdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_hwdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            if (w_gnt) begin
                r_hwdata <= wdata_i;
            end
        end
    end

    // Next-state: a grant always opens a data phase; hready releases the current one.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        if (w_gnt) begin
            w_valid_nxt = 1'b1;
        end else if (hready_i) begin
            w_valid_nxt = 1'b0;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hready_i) begin
                    w_state_nxt = w_gnt ? ST_DATA : ST_IDLE;
                end else if (hresp_i) begin
                    w_state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                if (hready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef AHB_MASTER_RSP_REG_EN
    logic                      r_rvalid;
    logic [AHB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rvalid;
            r_rdata  <= hrdata_i;
            r_err    <= w_err;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
`else
    assign rvalid_o = w_rvalid;
    assign rdata_o  = hrdata_i;
    assign err_o    = w_err;
`endif

endmodule
